yalu_pipe: RTL and testbench
============================

// Module: yalu_pipe
// PURPOSE
//  Parametrised, registered successor to yAlu for the pipelined RISC-V datapath. Executes
//  the yAlu op set (same 3-bit encodings), extended with XOR/NOR/SLTU, shifts and an
//  iterative multiply. Uses valid/ready handshakes on input and output, so the EX stage can stall.
//  Sits between ID/EX and EX/MEM; carries an opaque tag (rd index) alongside each result.
// PARAMETERS
//  WIDTH   32  operand/result width, >=4, power of 2
//  TAG_W   5   width of tag passed through with each op
//  MUL_EN  1   1: op MUL is implemented; 0: MUL is treated as illegal
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block accepts this cycle (accept = in_valid & in_ready)
//  a, b       in   WIDTH  operands; signed unless op is unsigned
//  op         in   4      operation code, see BEHAVIOUR
//  in_tag     in   TAG_W  tag captured with the op
//  out_valid  out  1      z/flags/out_tag valid
//  out_ready  in   1      consumer takes result (retire = out_valid & out_ready)
//  z          out  WIDTH  result
//  zero       out  1      z == 0 (same meaning as yAlu ex)
//  ovf        out  1      signed overflow; ADD/SUB only, else 0
//  illegal    out  1      op was unassigned; z = 0
//  out_tag    out  TAG_W  tag of the result
// BEHAVIOUR
//  op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 SLT (signed, z=0/1),
//      0011 XOR, 0100 NOR, 0101 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low WIDTH bits).
//      Any other op -> illegal=1, z=0, zero=1, latency 1.
//  Shifts: amount = b[$clog2(WIDTH)-1:0]; the upper bits of b are ignored.
//  ADD/SUB wrap mod 2^WIDTH; ovf = sign(a)==sign(b') && sign(z)!=sign(a), where b' = b for ADD and ~b for SUB.
//  FSM: IDLE, MUL, HOLD.
//   IDLE: in_ready = !out_valid | out_ready.
//    Single-cycle op accepted -> results registered; out_valid=1 next cycle (latency 1); stay IDLE.
//    MUL accepted -> capture a, b, tag; clear accumulator; count=0; go MUL; out_valid drops once the held result retires.
//   MUL: shift-add one bit of b per cycle; in_ready=0; count increments each cycle.
//    When count reaches WIDTH-1, load z; out_valid=1 next cycle. Total latency is WIDTH cycles from accept.
//    Go HOLD if !out_ready at that point, else IDLE.
//   HOLD: in_ready=0 until retire, then IDLE.
//  Output register holds z/flags/tag stable while out_valid & !out_ready (no drop, no overwrite).
//  Same-cycle retire + accept in IDLE: new result replaces old, out_valid stays 1 (full throughput).
//  No accept while out_valid & !out_ready.
//  Reset (any state, including mid-MUL): state=IDLE, out_valid=0, z=0, zero=0, ovf=0, illegal=0, out_tag=0.
//   The in-flight MUL is discarded. in_ready=1 in the cycle after reset deasserts.
//  MUL_EN=0: MUL is decoded as illegal; the MUL state is unreachable.
// TESTING
//  1 yAlu regression, WIDTH=32: random a/b (half with b=a), ops 0,1,2,6,7.
//    -> z matches the behavioural model, latency 1, zero==(z==0); a=b under SUB gives z=0, zero=1.
//  2 ovf: ADD 0x7FFFFFFF+1 -> z=0x80000000, ovf=1.
//    SUB 0x80000000-1 -> z=0x7FFFFFFF, ovf=1.
//    SLTU 1 vs 0xFFFFFFFF -> z=1; SLT -> z=0.
//  3 shifts: SRA 0x80000000 by b=0x24 (amount 4) -> 0xF8000000.
//    SRL -> 0x08000000; SLL 1 by 31 -> 0x80000000.
//  4 MUL: 7*6 -> z=42 with out_valid exactly 32 cycles after accept, in_ready=0 throughout.
//    0xFFFFFFFF*0xFFFFFFFF -> z=1.
//  5 backpressure: out_ready=0 for 5 cycles -> z/tag stable, in_ready=0.
//    Back-to-back stream with out_ready=1 -> one result per cycle, tags in order.
//  6 reset asserted at cycle 10 of a MUL -> next cycle out_valid=0, z=0, in_ready=1.
//    Op 1111 -> illegal=1, z=0; WIDTH=8 build passes tests 1-4.

Source files
------------

// File: rtl/yalu_pipe.sv
// Pipelined ALU for the EX stage: single-cycle logic/arith/shift ops, an iterative
// shift-add multiply, and a registered valid/ready output stage carrying a pass-through tag.
module yalu_pipe #(
   parameter int WIDTH  = 32,
   parameter int TAG_W  = 5,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             zero,
   output logic             ovf,
   output logic             illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;

   state_t             r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_z;
   logic               r_zero;
   logic               r_ovf;
   logic               r_illegal;
   logic [TAG_W-1:0]   r_tag;

   logic [WIDTH-1:0]   r_ma;
   logic [WIDTH-1:0]   r_mb;
   logic [WIDTH-1:0]   r_acc;
   logic [SH_W-1:0]    r_count;
   logic [TAG_W-1:0]   r_mtag;

   logic [SH_W-1:0]    w_shamt;
   logic [WIDTH-1:0]   w_b_eff;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_z;
   logic               w_ovf;
   logic               w_illegal;
   logic               w_is_mul;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_retire;
   logic               w_mul_last;
   logic [WIDTH-1:0]   w_acc_next;
   logic [WIDTH-1:0]   w_acc_fin;

   assign w_shamt    = b[SH_W-1:0];
   assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_retire   = r_out_valid && out_ready;

   // The MUL state lasts WIDTH-1 cycles, so the final step folds in the top
   // multiplier bit as a second partial product to keep latency at WIDTH.
   assign w_mul_last = (r_count == SH_W'(WIDTH - 2));
   assign w_acc_next = r_acc + (r_mb[0] ? r_ma : '0);
   assign w_acc_fin  = w_acc_next + (r_mb[1] ? (r_ma << 1) : '0);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_z       = '0;
      w_ovf     = 1'b0;
      w_illegal = 1'b0;
      w_is_mul  = 1'b0;
      w_b_eff   = (op == OP_SUB) ? ~b : b;
      w_sum     = a + w_b_eff + {{(WIDTH-1){1'b0}}, (op == OP_SUB)};
      case (op)
         OP_AND:  w_z = a & b;
         OP_OR:   w_z = a | b;
         OP_XOR:  w_z = a ^ b;
         OP_NOR:  w_z = ~(a | b);
         OP_ADD, OP_SUB: begin
            w_z   = w_sum;
            w_ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  w_z = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: w_z = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  w_z = a << w_shamt;
         OP_SRL:  w_z = a >> w_shamt;
         OP_SRA:  w_z = $signed(a) >>> w_shamt;
         OP_MUL: begin
            if (MUL_EN != 0) w_is_mul  = 1'b1;
            else             w_illegal = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_z         <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_illegal   <= 1'b0;
         r_tag       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_MUL;
               end else if (w_accept) begin
                  r_z         <= w_z;
                  r_zero      <= (w_z == '0);
                  r_ovf       <= w_ovf;
                  r_illegal   <= w_illegal;
                  r_tag       <= in_tag;
                  r_out_valid <= 1'b1;
               end else if (w_retire) begin
                  r_out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               if (w_mul_last) begin
                  r_z         <= w_acc_fin;
                  r_zero      <= (w_acc_fin == '0);
                  r_ovf       <= 1'b0;
                  r_illegal   <= 1'b0;
                  r_tag       <= r_mtag;
                  r_out_valid <= 1'b1;
                  r_state     <= out_ready ? ST_IDLE : ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: multiplier datapath has no reset; the FSM never reads it before an accept loads it.
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && w_accept && w_is_mul) begin
         r_ma    <= a;
         r_mb    <= b;
         r_acc   <= '0;
         r_count <= '0;
         r_mtag  <= in_tag;
      end else if (r_state == ST_MUL) begin
         r_acc   <= w_acc_next;
         r_ma    <= r_ma << 1;
         r_mb    <= r_mb >> 1;
         r_count <= r_count + 1'b1;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign z         = r_z;
   assign zero      = r_zero;
   assign ovf       = r_ovf;
   assign illegal   = r_illegal;
   assign out_tag   = r_tag;

endmodule

// File: tb/tb_yalu_pipe.sv
// Scoreboard bench for yalu_pipe: a driver pushes expected results, a negedge monitor
// pops and compares on every retire; a second WIDTH=8 instance covers the narrow build.
module tb_yalu_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0, b = '0;
   logic [3:0]  op = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] z;
   logic        zero, ovf, illegal;
   logic [4:0]  out_tag;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [3:0]  op8 = '0;
   logic [4:0]  in_tag8 = '0;
   logic        out_valid8;
   logic        out_ready8 = 1'b1;
   logic [7:0]  z8;
   logic        zero8, ovf8, illegal8;
   logic [4:0]  out_tag8;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [31:0] z;
      logic        zero;
      logic        ovf;
      logic        ill;
      logic [4:0]  tag;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   yalu_pipe #(.WIDTH(32), .TAG_W(5), .MUL_EN(1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .zero(zero), .ovf(ovf), .illegal(illegal), .out_tag(out_tag)
   );

   yalu_pipe #(.WIDTH(8), .TAG_W(5), .MUL_EN(1)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .op(op8), .in_tag(in_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
      .z(z8), .zero(zero8), .ovf(ovf8), .illegal(illegal8), .out_tag(out_tag8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: tag %0d z 0x%0h with empty scoreboard", out_tag, z);
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("tag%0d_z", mon_e.tag), z, mon_e.z);
            check($sformatf("tag%0d_zero", mon_e.tag), zero, mon_e.zero);
            check($sformatf("tag%0d_ovf", mon_e.tag), ovf, mon_e.ovf);
            check($sformatf("tag%0d_illegal", mon_e.tag), illegal, mon_e.ill);
            check($sformatf("tag%0d_out_tag", mon_e.tag), out_tag, mon_e.tag);
            if (mon_e.lat >= 0)
               check($sformatf("tag%0d_latency", mon_e.tag), cyc - mon_e.acc, mon_e.lat);
         end
      end
   end

   // Entered and left at posedge+1; pushes the expectation in the cycle of acceptance.
   task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] t, input logic [31:0] ez, input logic eovf,
                        input logic eill, input int lat);
      exp_t e;
      int   waited = 0;
      op = o; a = av; b = bv; in_tag = t; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) break;
         @(posedge clk);
         #1;
      end
      if (waited > 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: tag %0d never accepted", t);
      end else begin
         e.z = ez; e.zero = (ez == 32'd0); e.ovf = eovf; e.ill = eill;
         e.tag = t; e.lat = lat; e.acc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic v);
      logic [32:0] s;
      r = '0;
      v = 1'b0;
      s = '0;
      case (o)
         4'd0: r = x & y;
         4'd1: r = x | y;
         4'd2: begin s = {x[31], x} + {y[31], y}; r = s[31:0]; v = s[32] ^ s[31]; end
         4'd6: begin s = {x[31], x} - {y[31], y}; r = s[31:0]; v = s[32] ^ s[31]; end
         4'd7: r = {31'd0, ($signed(x) < $signed(y))};
         default: r = '0;
      endcase
   endfunction

   task automatic run8(input string nm, input logic [3:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] ez, input logic eovf, input int elat);
      int n = 0;
      op8 = o; a8 = av; b8 = bv; in_valid8 = 1'b1;
      @(negedge clk);
      while (!in_ready8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_z"}, z8, ez);
      check({nm, "_zero"}, zero8, (ez == 8'd0));
      check({nm, "_ovf"}, ovf8, eovf);
      check({nm, "_latency"}, n, elat);
      @(posedge clk);
      #1;
   endtask

   logic [3:0] ops_tbl [0:4];

   initial begin
      logic [31:0] ra, rb, rz;
      logic        rv;
      logic [3:0]  ro;
      logic [4:0]  t;
      ops_tbl[0] = 4'd0; ops_tbl[1] = 4'd1; ops_tbl[2] = 4'd2; ops_tbl[3] = 4'd6; ops_tbl[4] = 4'd7;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_z", z, 32'd0);
      check("reset_zero", zero, 1'b0);
      check("reset_out_tag", out_tag, 5'd0);
      check("reset_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // yAlu regression with a behavioural model; half the vectors use b == a
      t = 5'd1;
      for (int i = 0; i < 20; i++) begin
         ra = $urandom();
         rb = (i % 2 == 0) ? ra : $urandom();
         ro = ops_tbl[$urandom_range(0, 4)];
         model(ro, ra, rb, rz, rv);
         issue(ro, ra, rb, t, rz, rv, 1'b0, 1);
         t = t + 5'd1;
      end
      issue(4'b0110, 32'h1234_5678, 32'h1234_5678, 5'd21, 32'h0, 1'b0, 1'b0, 1);
      drain();

      // overflow, compares, XOR/NOR, shifts, illegal
      issue(4'b0010, 32'h7FFF_FFFF, 32'h1,         5'd1, 32'h8000_0000, 1'b1, 1'b0, 1);
      issue(4'b0110, 32'h8000_0000, 32'h1,         5'd2, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
      issue(4'b0101, 32'h1,         32'hFFFF_FFFF, 5'd3, 32'h1,         1'b0, 1'b0, 1);
      issue(4'b0111, 32'h1,         32'hFFFF_FFFF, 5'd4, 32'h0,         1'b0, 1'b0, 1);
      issue(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5, 32'h0FF0_0FF0, 1'b0, 1'b0, 1);
      issue(4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd6, 32'h0000_0F0F, 1'b0, 1'b0, 1);
      issue(4'b1010, 32'h8000_0000, 32'h24,        5'd7, 32'hF800_0000, 1'b0, 1'b0, 1);
      issue(4'b1001, 32'h8000_0000, 32'h24,        5'd8, 32'h0800_0000, 1'b0, 1'b0, 1);
      issue(4'b1000, 32'h1,         32'd31,        5'd9, 32'h8000_0000, 1'b0, 1'b0, 1);
      issue(4'b1111, 32'h5,         32'h3,         5'd10, 32'h0,        1'b0, 1'b1, 1);
      issue(4'b1011, 32'h5,         32'h3,         5'd11, 32'h0,        1'b0, 1'b1, 1);
      drain();

      // multiply: in_ready low for the 31 cycles before the result
      issue(4'b1100, 32'd7, 32'd6, 5'd12, 32'd42, 1'b0, 1'b0, 32);
      begin
         logic busy_ok = 1'b1;
         for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (in_ready) busy_ok = 1'b0;
         end
         check("mul_in_ready_low", busy_ok, 1'b1);
      end
      @(posedge clk);
      #1;
      drain();
      issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h1, 1'b0, 1'b0, 32);
      drain();

      // backpressure: result and tag held, no accept while stalled
      out_ready = 1'b0;
      issue(4'b0001, 32'h00FF_00FF, 32'h0F00_0000, 5'd14, 32'h0FFF_00FF, 1'b0, 1'b0, -1);
      in_valid = 1'b1;
      op = 4'b0010; a = 32'd1; b = 32'd1; in_tag = 5'd30;
      begin
         logic hold_ok = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (z !== 32'h0FFF_00FF || out_tag !== 5'd14 || out_valid !== 1'b1 || in_ready !== 1'b0)
               hold_ok = 1'b0;
         end
         check("backpressure_hold", hold_ok, 1'b1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // back-to-back stream: one result per cycle, tags in order
      for (int i = 0; i < 6; i++)
         issue(4'b0010, 32'(i), 32'd100, 5'(16 + i), 32'(100 + i), 1'b0, 1'b0, 1);
      drain();

      // reset at cycle 10 of a multiply discards it
      issue(4'b1100, 32'd9, 32'd9, 5'd25, 32'd81, 1'b0, 1'b0, 32);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midmul_reset_out_valid", out_valid, 1'b0);
      check("midmul_reset_z", z, 32'd0);
      check("midmul_reset_in_ready", in_ready, 1'b1);
      check("midmul_reset_out_tag", out_tag, 5'd0);
      @(posedge clk);
      #1;
      issue(4'b0010, 32'd2, 32'd3, 5'd26, 32'd5, 1'b0, 1'b0, 1);
      drain();

      // narrow build
      run8("w8_add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b1, 1);
      run8("w8_sub_ovf", 4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1, 1);
      run8("w8_sub_eq",  4'b0110, 8'h33, 8'h33, 8'h00, 1'b0, 1);
      run8("w8_and",     4'b0000, 8'hA5, 8'h0F, 8'h05, 1'b0, 1);
      run8("w8_or",      4'b0001, 8'hA0, 8'h05, 8'hA5, 1'b0, 1);
      run8("w8_sltu",    4'b0101, 8'h01, 8'hFF, 8'h01, 1'b0, 1);
      run8("w8_slt",     4'b0111, 8'h01, 8'hFF, 8'h00, 1'b0, 1);
      run8("w8_sra",     4'b1010, 8'h80, 8'h0C, 8'hF8, 1'b0, 1);
      run8("w8_srl",     4'b1001, 8'h80, 8'h0C, 8'h08, 1'b0, 1);
      run8("w8_sll",     4'b1000, 8'h01, 8'h07, 8'h80, 1'b0, 1);
      run8("w8_mul",     4'b1100, 8'h07, 8'h06, 8'h2A, 1'b0, 8);
      run8("w8_mul_ff",  4'b1100, 8'hFF, 8'hFF, 8'h01, 1'b0, 8);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
